// File: rtl/keyframe_sequencer.sv
// Double-banked keyframe sequencer: captures decoder writes into the staging bank,
// arbitrates the shared single-port channel RAM, and swaps banks at keyframe boundaries.
module keyframe_sequencer #(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = 12,
  parameter int c_max_time  = 1024,
  parameter int c_max_type  = 64,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_time_w    = $clog2(c_max_time),
  parameter int c_type_w    = $clog2(c_max_type)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wen,
  input  logic [c_addr_w-1:0] i_addr,
  input  logic [c_bpc-1:0]    i_data,
  input  logic [c_time_w-1:0] i_time,
  input  logic [c_type_w-1:0] i_type,
  input  logic                i_tick,
  input  logic                i_rd_req,
  input  logic [c_addr_w-1:0] i_rd_addr,
  output logic                o_rd_gnt,
  output logic                o_rd_valid,
  output logic [c_bpc-1:0]    o_rd_data,
  output logic                o_ram_en,
  output logic                o_ram_we,
  output logic [c_addr_w:0]   o_ram_addr,
  output logic [c_bpc-1:0]    o_ram_wdata,
  input  logic [c_bpc-1:0]    i_ram_rdata,
  output logic                o_bank,
  output logic [c_time_w-1:0] o_progress,
  output logic [c_time_w-1:0] o_duration,
  output logic [c_type_w-1:0] o_type,
  output logic                o_busy,
  output logic                o_pending,
  output logic                o_overrun
);

  // Handshake: the reader holds i_rd_req with a stable i_rd_addr until o_rd_gnt is
  // seen high in the same cycle; o_rd_valid/o_rd_data follow exactly one cycle later.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);

  state_e                state_q, state_d;
  logic                  wen_prev_q, wen_prev_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [c_addr_w-1:0]   wb_addr_q, wb_addr_d;
  logic [c_bpc-1:0]      wb_data_q, wb_data_d;
  logic [c_time_w-1:0]   wb_time_q, wb_time_d;
  logic [c_type_w-1:0]   wb_type_q, wb_type_d;
  logic [c_time_w-1:0]   stg_time_q, stg_time_d;
  logic [c_type_w-1:0]   stg_type_q, stg_type_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  bank_q, bank_d;
  logic [c_time_w-1:0]   progress_q, progress_d;
  logic [c_time_w-1:0]   duration_q, duration_d;
  logic [c_type_w-1:0]   type_q, type_d;
  logic [c_time_w-1:0]   progress_inc;

  assign progress_inc = progress_q + 1'b1;

  // Buffered write always wins the RAM port; reads use the current display bank.
  assign o_rd_gnt    = i_rd_req & ~wb_valid_q;
  assign o_ram_en    = wb_valid_q | i_rd_req;
  assign o_ram_we    = wb_valid_q;
  assign o_ram_addr  = wb_valid_q ? {~bank_q, wb_addr_q} :
                       (i_rd_req ? {bank_q, i_rd_addr} : '0);
  assign o_ram_wdata = wb_valid_q ? wb_data_q : '0;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_valid_q ? i_ram_rdata : '0;
  assign o_bank      = bank_q;
  assign o_progress  = progress_q;
  assign o_duration  = duration_q;
  assign o_type      = type_q;
  assign o_busy      = (state_q == S_RUN);
  assign o_pending   = pending_q;
  assign o_overrun   = overrun_q;

  always_comb begin
    state_d    = state_q;
    wen_prev_d = i_wen;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_time_d  = wb_time_q;
    wb_type_d  = wb_type_q;
    stg_time_d = stg_time_q;
    stg_type_d = stg_type_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    rd_valid_d = o_rd_gnt;
    bank_d     = bank_q;
    progress_d = progress_q;
    duration_d = duration_q;
    type_d     = type_q;

    if (wb_valid_q) begin
      wb_valid_d = 1'b0;
      if (wb_addr_q == c_last_addr) begin
        stg_time_d = wb_time_q;
        stg_type_d = wb_type_q;
        pending_d  = 1'b1;
      end
    end

    // wb_valid_q is high in the frame-completing write cycle, so a capture can
    // never land while a swap is being armed.
    if (i_wen && !wen_prev_q) begin
      if (wb_valid_q || pending_q || (i_addr > c_last_addr)) begin
        overrun_d = 1'b1;
      end else begin
        wb_valid_d = 1'b1;
        wb_addr_d  = i_addr;
        wb_data_d  = i_data;
        wb_time_d  = i_time;
        wb_type_d  = i_type;
      end
    end

    case (state_q)
      S_RUN: begin
        if (i_tick && (progress_q < duration_q)) begin
          progress_d = progress_inc;
          if (progress_inc == duration_q) state_d = S_HOLD;
        end
      end
      default: begin
        if (pending_q) begin
          bank_d     = ~bank_q;
          duration_d = stg_time_q;
          type_d     = stg_type_q;
          progress_d = '0;
          pending_d  = 1'b0;
          state_d    = (stg_time_q == '0) ? S_HOLD : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      wen_prev_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_time_q  <= '0;
      wb_type_q  <= '0;
      stg_time_q <= '0;
      stg_type_q <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      bank_q     <= 1'b0;
      progress_q <= '0;
      duration_q <= '0;
      type_q     <= '0;
    end else begin
      state_q    <= state_d;
      wen_prev_q <= wen_prev_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_time_q  <= wb_time_d;
      wb_type_q  <= wb_type_d;
      stg_time_q <= stg_time_d;
      stg_type_q <= stg_type_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      bank_q     <= bank_d;
      progress_q <= progress_d;
      duration_q <= duration_d;
      type_q     <= type_d;
    end
  end

endmodule

// File: tb/tb_keyframe_sequencer.sv
// Directed scoreboard bench for keyframe_sequencer with a behavioural 1-cycle channel RAM.
module tb_keyframe_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [9:0]  addr;
  logic [11:0] data;
  logic [9:0]  ktime;
  logic [5:0]  ktype;
  logic        tick;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic        bank;
  logic [9:0]  progress;
  logic [9:0]  duration;
  logic [5:0]  ftype;
  logic        busy;
  logic        pending;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;

  logic [22:0] exp_wr_q[$];
  logic [11:0] exp_rd_q[$];
  logic [11:0] exp_mem[0:2047];
  logic [11:0] ram_mem[0:2047];
  logic        exp_bank;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  keyframe_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_addr(addr), .i_data(data),
    .i_time(ktime), .i_type(ktype), .i_tick(tick), .i_rd_req(rd_req),
    .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_bank(bank), .o_progress(progress), .o_duration(duration), .o_type(ftype),
    .o_busy(busy), .o_pending(pending), .o_overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (ram_en && ram_we) begin
      n_wr++;
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ram_write: got unexpected %0h required none", {ram_addr, ram_wdata});
      end else begin
        check("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_wr_q.pop_front()));
      end
    end
    if (rd_valid) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data: got unexpected %0h required none", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [11:0] chan_val(input int a, input int tag);
    return 12'(a * 5 + tag * 37);
  endfunction

  task automatic write_one(input logic [9:0] a, input logic [11:0] d, input logic [9:0] t,
                           input logic [5:0] ty, input bit accept);
    @(posedge clk);
    #1;
    wen = 1'b1; addr = a; data = d; ktime = t; ktype = ty;
    if (accept) begin
      exp_wr_q.push_back({~exp_bank, a, d});
      exp_mem[{~exp_bank, a}] = d;
    end
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic write_frame(input logic [9:0] t, input logic [5:0] ty, input int tag, input int last);
    for (int a = 0; a <= last; a++) write_one(10'(a), chan_val(a, tag), t, ty, 1'b1);
  endtask

  task automatic tick_pulse();
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bank"}, 32'(bank), 0);
    check({tag, "_progress"}, 32'(progress), 0);
    check({tag, "_duration"}, 32'(duration), 0);
    check({tag, "_type"}, 32'(ftype), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_ram_en"}, 32'(ram_en), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int ng;
    int nz;
    logic       granted;
    logic [9:0] ra;

    rst_n = 1'b0; wen = 1'b0; addr = '0; data = '0; ktime = '0; ktype = '0;
    tick = 1'b0; rd_req = 1'b0; rd_addr = '0; exp_bank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame 1: duration 3, type 5 -> bank 1
    w0 = n_wr;
    write_frame(10'd3, 6'd5, 1, 959);
    @(posedge clk);
    @(negedge clk);
    check("f1_writes", 32'(n_wr - w0), 960);
    check("f1_pending", 32'(pending), 1);
    check("f1_bank_preswap", 32'(bank), 0);
    @(posedge clk);
    @(negedge clk);
    exp_bank = 1'b1;
    check("f1_bank", 32'(bank), 32'(exp_bank));
    check("f1_busy", 32'(busy), 1);
    check("f1_duration", 32'(duration), 3);
    check("f1_type", 32'(ftype), 5);
    check("f1_pending_clr", 32'(pending), 0);
    check("f1_progress0", 32'(progress), 0);

    tick_pulse(); check("tick1_progress", 32'(progress), 1); check("tick1_busy", 32'(busy), 1);
    tick_pulse(); check("tick2_progress", 32'(progress), 2);
    tick_pulse(); check("tick3_progress", 32'(progress), 3); check("tick3_busy", 32'(busy), 0);
    tick_pulse(); check("tick4_saturate", 32'(progress), 3);

    // Long write strobe with a continuous reader
    w0 = n_wr; ng = 0; nz = 0; ra = '0;
    @(posedge clk);
    #1;
    wen = 1'b1; addr = 10'd5; data = 12'h0ab; ktime = 10'd1; ktype = 6'd1;
    rd_req = 1'b1; rd_addr = ra;
    exp_wr_q.push_back({1'b0, 10'd5, 12'h0ab});
    exp_mem[{1'b0, 10'd5}] = 12'h0ab;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      granted = rd_gnt;
      if (granted) begin
        exp_rd_q.push_back(exp_mem[{exp_bank, ra}]);
        ng++;
      end else begin
        nz++;
      end
      @(posedge clk);
      #1;
      if (granted) begin
        ra = ra + 10'd1;
        rd_addr = ra;
      end
    end
    wen = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("hold_wen_writes", 32'(n_wr - w0), 1);
    check("hold_gnt_count", 32'(ng), 19);
    check("hold_gnt_low", 32'(nz), 1);

    // Frame 2: duration 10, type 7 -> bank 0, running
    write_frame(10'd10, 6'd7, 2, 959);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    exp_bank = 1'b0;
    check("f2_bank", 32'(bank), 32'(exp_bank));
    check("f2_duration", 32'(duration), 10);
    check("f2_busy", 32'(busy), 1);
    tick_pulse();
    tick_pulse();
    check("f2_progress2", 32'(progress), 2);

    // Frame 3 (duration 0, type 9) arrives while frame 2 runs
    write_frame(10'd0, 6'd9, 3, 959);
    @(posedge clk);
    @(negedge clk);
    check("f3_pending", 32'(pending), 1);
    check("f3_no_swap", 32'(bank), 0);
    check("f3_busy", 32'(busy), 1);
    check("f3_overrun_clear", 32'(overrun), 0);
    w0 = n_wr;
    write_one(10'd10, 12'h777, 10'd4, 6'd4, 1'b0);
    @(negedge clk);
    check("drop_overrun", 32'(overrun), 1);
    check("drop_no_write", 32'(n_wr - w0), 0);
    for (int k = 3; k <= 9; k++) tick_pulse();
    check("f2_progress9", 32'(progress), 9);
    check("f2_still_pending", 32'(pending), 1);
    tick_pulse();
    check("f2_progress10", 32'(progress), 10);
    check("f2_hold", 32'(busy), 0);
    check("f2_bank_before_swap", 32'(bank), 0);
    @(negedge clk);
    exp_bank = 1'b1;
    check("f3_bank", 32'(bank), 32'(exp_bank));
    check("f3_duration", 32'(duration), 0);
    check("f3_type", 32'(ftype), 9);
    check("f3_progress", 32'(progress), 0);
    check("f3_hold_busy", 32'(busy), 0);
    check("f3_pending_clr", 32'(pending), 0);
    tick_pulse();
    check("f3_tick_progress", 32'(progress), 0);

    // Reset mid-frame
    write_frame(10'd6, 6'd2, 4, 399);
    @(posedge clk);
    #1;
    wen = 1'b1; addr = 10'd400; data = 12'h123;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    wen = 1'b0;
    exp_bank = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame after reset: duration 2, type 3 -> bank 1
    write_frame(10'd2, 6'd3, 5, 959);
    @(posedge clk);
    @(negedge clk);
    check("f5_pending", 32'(pending), 1);
    @(posedge clk);
    @(negedge clk);
    exp_bank = 1'b1;
    check("f5_bank", 32'(bank), 32'(exp_bank));
    check("f5_duration", 32'(duration), 2);
    check("f5_type", 32'(ftype), 3);
    check("f5_busy", 32'(busy), 1);

    repeat (2) @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
